// File: rtl/router_pkt_tx.sv
// router_pkt_tx: packet transmitter for the 1x3 router input port.
//
// Buffers one payload (1..63 bytes) from an upstream byte source while
// accumulating the even-XOR parity over header and payload. It then drives
// header, payload and parity bytes onto the router input, honouring busy.
//
// Ports:
//   clock           sole clock, rising edge
//   reset           synchronous, active-high reset
//   start           request to send one packet (sampled in IDLE only)
//   dest_addr[1:0]  destination port 0..2 (3 is rejected)
//   payload_len[5:0] payload byte count 1..63 (0 is rejected)
//   corrupt_parity  error-injection request, sampled with start
//   src_valid       upstream byte valid
//   src_data[7:0]   upstream payload byte
//   src_ready       block accepts src_data this cycle (LOAD)
//   busy            router cannot accept a byte this cycle
//   pkt_valid       high during header and payload, low during parity
//   data_out[7:0]   byte to router data_in
//   tx_active       high whenever not IDLE
//   tx_done         one-cycle pulse after the parity byte is accepted
//   bad_req         one-cycle pulse when start is rejected
//
// Build option: define ROUTER_TX_PARITY_CORRUPT_EN to make corrupt_parity
// invert bit 0 of the transmitted parity byte. Undefined, corrupt_parity is
// ignored and parity is always correct.

module router_pkt_tx (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] dest_addr,
  input  logic [5:0] payload_len,
  input  logic       corrupt_parity,
  input  logic       src_valid,
  input  logic [7:0] src_data,
  output logic       src_ready,
  input  logic       busy,
  output logic       pkt_valid,
  output logic [7:0] data_out,
  output logic       tx_active,
  output logic       tx_done,
  output logic       bad_req
);

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StLoad    = 3'd1;
  localparam logic [2:0] StHeader  = 3'd2;
  localparam logic [2:0] StPayload = 3'd3;
  localparam logic [2:0] StParity  = 3'd4;

  logic [2:0] state_q, state_d;
  logic [7:0] header_q, header_d;
  logic [7:0] parity_q, parity_d;
  logic [5:0] idx_q, idx_d;
  logic       pkt_valid_q, pkt_valid_d;
  logic [7:0] data_out_q, data_out_d;
  logic       tx_done_q, tx_done_d;
  logic       bad_req_q, bad_req_d;
  logic       buf_we;
  logic [7:0] parity_tx;
  logic [5:0] last_idx;

  // Payload buffer; contents are not reset.
  logic [7:0] buf_mem [63];

  assign last_idx = header_q[7:2] - 6'd1;

`ifdef ROUTER_TX_PARITY_CORRUPT_EN
  logic corrupt_q, corrupt_d;
  assign parity_tx = parity_q ^ {7'b0, corrupt_q};
`else
  logic unused_corrupt;
  assign unused_corrupt = corrupt_parity;
  assign parity_tx      = parity_q;
`endif

  always_comb begin
    state_d     = state_q;
    header_d    = header_q;
    parity_d    = parity_q;
    idx_d       = idx_q;
    pkt_valid_d = pkt_valid_q;
    data_out_d  = data_out_q;
    tx_done_d   = 1'b0;
    bad_req_d   = 1'b0;
    buf_we      = 1'b0;
`ifdef ROUTER_TX_PARITY_CORRUPT_EN
    corrupt_d   = corrupt_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (payload_len == 6'd0 || dest_addr == 2'd3) begin
            bad_req_d = 1'b1;
          end else begin
            header_d = {payload_len, dest_addr};
            parity_d = {payload_len, dest_addr};
            idx_d    = 6'd0;
            state_d  = StLoad;
`ifdef ROUTER_TX_PARITY_CORRUPT_EN
            corrupt_d = corrupt_parity;
`endif
          end
        end
      end
      StLoad: begin
        if (src_valid) begin
          buf_we   = 1'b1;
          parity_d = parity_q ^ src_data;
          if (idx_q == last_idx) begin
            // Present the header the cycle after the last byte is written.
            idx_d       = 6'd0;
            state_d     = StHeader;
            pkt_valid_d = 1'b1;
            data_out_d  = header_q;
          end else begin
            idx_d = idx_q + 6'd1;
          end
        end
      end
      StHeader: begin
        if (!busy) begin
          state_d    = StPayload;
          data_out_d = buf_mem[0];
        end
      end
      StPayload: begin
        if (!busy) begin
          if (idx_q == last_idx) begin
            state_d     = StParity;
            pkt_valid_d = 1'b0;
            data_out_d  = parity_tx;
          end else begin
            idx_d      = idx_q + 6'd1;
            data_out_d = buf_mem[idx_q + 6'd1];
          end
        end
      end
      StParity: begin
        if (!busy) begin
          state_d    = StIdle;
          tx_done_d  = 1'b1;
          data_out_d = 8'h00;
        end
      end
      default: begin
        state_d     = StIdle;
        pkt_valid_d = 1'b0;
        data_out_d  = 8'h00;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StIdle;
      header_q    <= 8'h00;
      parity_q    <= 8'h00;
      idx_q       <= 6'd0;
      pkt_valid_q <= 1'b0;
      data_out_q  <= 8'h00;
      tx_done_q   <= 1'b0;
      bad_req_q   <= 1'b0;
`ifdef ROUTER_TX_PARITY_CORRUPT_EN
      corrupt_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      header_q    <= header_d;
      parity_q    <= parity_d;
      idx_q       <= idx_d;
      pkt_valid_q <= pkt_valid_d;
      data_out_q  <= data_out_d;
      tx_done_q   <= tx_done_d;
      bad_req_q   <= bad_req_d;
`ifdef ROUTER_TX_PARITY_CORRUPT_EN
      corrupt_q   <= corrupt_d;
`endif
    end
  end

  always_ff @(posedge clock) begin
    if (buf_we) begin
      buf_mem[idx_q] <= src_data;
    end
  end

  assign src_ready = (state_q == StLoad);
  assign tx_active = (state_q != StIdle);
  assign pkt_valid = pkt_valid_q;
  assign data_out  = data_out_q;
  assign tx_done   = tx_done_q;
  assign bad_req   = bad_req_q;

endmodule

// File: tb/tb_router_pkt_tx.sv
module tb_router_pkt_tx;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic [1:0] dest_addr;
  logic [5:0] payload_len;
  logic       corrupt_parity;
  logic       src_valid;
  logic [7:0] src_data;
  logic       src_ready;
  logic       busy;
  logic       pkt_valid;
  logic [7:0] data_out;
  logic       tx_active;
  logic       tx_done;
  logic       bad_req;

`ifdef ROUTER_TX_PARITY_CORRUPT_EN
  localparam bit CorruptEn = 1'b1;
`else
  localparam bit CorruptEn = 1'b0;
`endif

  router_pkt_tx dut (
    .clock          (clock),
    .reset          (reset),
    .start          (start),
    .dest_addr      (dest_addr),
    .payload_len    (payload_len),
    .corrupt_parity (corrupt_parity),
    .src_valid      (src_valid),
    .src_data       (src_data),
    .src_ready      (src_ready),
    .busy           (busy),
    .pkt_valid      (pkt_valid),
    .data_out       (data_out),
    .tx_active      (tx_active),
    .tx_done        (tx_done),
    .bad_req        (bad_req)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: a packet is a list of bytes (header, payload, parity);
  // transmission walks a position through that list on each accepted edge.
  int         m_phase;  // 0 idle, 1 collecting payload, 2 transmitting
  int         m_len;
  int         m_pos;
  bit         m_corrupt;
  logic [7:0] m_bytes[$];
  logic [7:0] m_hdr;
  logic [7:0] m_par;
  logic       m_pv;
  logic [7:0] m_do;
  logic       m_done;
  logic       m_bad;

  initial begin
    m_phase = 0; m_pv = 1'b0; m_do = 8'h00; m_done = 1'b0; m_bad = 1'b0;
    forever begin
      @(posedge clock);
      cyc++;
      if (reset) begin
        m_phase = 0; m_pv = 1'b0; m_do = 8'h00; m_done = 1'b0; m_bad = 1'b0;
        m_bytes.delete();
      end else begin
        m_done = 1'b0;
        m_bad  = 1'b0;
        case (m_phase)
          0: if (start) begin
            if (payload_len == 6'd0 || dest_addr == 2'd3) begin
              m_bad = 1'b1;
            end else begin
              m_len     = int'(payload_len);
              m_hdr     = {payload_len, dest_addr};
              m_corrupt = CorruptEn && corrupt_parity;
              m_bytes.delete();
              m_bytes.push_back(m_hdr);
              m_phase = 1;
            end
          end
          1: if (src_valid) begin
            m_bytes.push_back(src_data);
            if (m_bytes.size() == m_len + 1) begin
              m_par = 8'h00;
              foreach (m_bytes[i]) m_par ^= m_bytes[i];
              if (m_corrupt) m_par ^= 8'h01;
              m_bytes.push_back(m_par);
              m_phase = 2;
              m_pos   = 0;
              m_pv    = 1'b1;
              m_do    = m_bytes[0];
            end
          end
          2: if (!busy) begin
            m_pos++;
            if (m_pos == m_len + 2) begin
              m_phase = 0; m_done = 1'b1; m_pv = 1'b0; m_do = 8'h00;
            end else begin
              m_do = m_bytes[m_pos];
              m_pv = (m_pos <= m_len);
            end
          end
          default: m_phase = 0;
        endcase
      end
    end
  end

  // Per-cycle comparison plus capture of every accepted transmit byte.
  logic [8:0] cap[$];
  int         hold22;

  initial begin
    forever begin
      @(negedge clock);
      if (cyc > 0) begin
        chk("pkt_valid", int'(pkt_valid), int'(m_pv));
        chk("data_out", int'(data_out), int'(m_do));
        chk("tx_done", int'(tx_done), int'(m_done));
        chk("bad_req", int'(bad_req), int'(m_bad));
        chk("src_ready", int'(src_ready), int'(m_phase == 1));
        chk("tx_active", int'(tx_active), int'(m_phase != 0));
      end
      if (tx_active && !src_ready && !busy) cap.push_back({pkt_valid, data_out});
      if (tx_active && pkt_valid && data_out == 8'h22) hold22++;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  logic [7:0] src_bytes[$];
  int         start_cyc;
  int         done_cyc;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic start_pkt(input logic [1:0] d, input logic [5:0] l, input bit c);
    start = 1'b1; dest_addr = d; payload_len = l; corrupt_parity = c;
    tick();
    start = 1'b0; corrupt_parity = 1'b0;
    start_cyc = cyc;
  endtask

  // mode 0: no stalls, 1: one idle cycle before each byte, 2: random stalls/busy/start
  task automatic feed(input int first, input int cnt, input int mode);
    for (int i = first; i < first + cnt; i++) begin
      if (mode == 1 || (mode == 2 && $urandom_range(2) == 0)) begin
        src_valid = 1'b0; src_data = 8'($urandom);
        if (mode == 2) busy = 1'($urandom);
        tick();
      end
      src_valid = 1'b1;
      src_data  = src_bytes[i];
      if (mode == 2) begin
        busy  = 1'($urandom);
        start = 1'($urandom);
        dest_addr = 2'($urandom); payload_len = 6'($urandom);
      end
      tick();
    end
    src_valid = 1'b0; src_data = 8'h00; start = 1'b0; busy = 1'b0;
  endtask

  // mode 0: never busy, 1: busy for 3 cycles while 0x22 shown, 2: random busy
  task automatic run_tx(input int mode);
    int hold;
    hold = 0;
    done_cyc = -1;
    for (int k = 0; k < 3000; k++) begin
      case (mode)
        1: if (pkt_valid && data_out == 8'h22 && hold < 3) begin
          busy = 1'b1; hold++;
        end else busy = 1'b0;
        2: busy = ($urandom_range(2) == 0);
        default: busy = 1'b0;
      endcase
      tick();
      if (tx_done) begin
        done_cyc = cyc;
        break;
      end
    end
    busy = 1'b0;
    if (done_cyc < 0) chk("tx_done timeout", 0, 1);
  endtask

  task automatic reject(input logic [1:0] d, input logic [5:0] l, input string nm);
    start_pkt(d, l, 1'b0);
    chk({nm, " bad_req pulse"}, int'(bad_req), 1);
    chk({nm, " tx_active"}, int'(tx_active), 0);
    chk({nm, " src_ready"}, int'(src_ready), 0);
    tick();
    chk({nm, " bad_req end"}, int'(bad_req), 0);
    chk({nm, " tx_active after"}, int'(tx_active), 0);
  endtask

  task automatic check_basic(input string nm, input logic [7:0] par);
    chk({nm, " byte count"}, cap.size(), 5);
    if (cap.size() == 5) begin
      chk({nm, " header"}, int'(cap[0]), 9'h10D);
      chk({nm, " byte0"}, int'(cap[1]), 9'h111);
      chk({nm, " byte1"}, int'(cap[2]), 9'h122);
      chk({nm, " byte2"}, int'(cap[3]), 9'h133);
      chk({nm, " parity"}, int'(cap[4]), {1'b0, par});
    end
  endtask

  logic [7:0] exp_par;

  initial begin
    reset = 1'b1; start = 1'b0; dest_addr = 2'd0; payload_len = 6'd0;
    corrupt_parity = 1'b0; src_valid = 1'b0; src_data = 8'h00; busy = 1'b0;
    hold22 = 0;
    repeat (3) tick();
    chk("reset pkt_valid", int'(pkt_valid), 0);
    chk("reset data_out", int'(data_out), 0);
    chk("reset tx_active", int'(tx_active), 0);
    chk("reset src_ready", int'(src_ready), 0);
    reset = 1'b0;
    tick();

    // Basic packet
    src_bytes = '{8'h11, 8'h22, 8'h33};
    cap.delete();
    start_pkt(2'd1, 6'd3, 1'b0);
    feed(0, 3, 0);
    chk("basic header after load", int'(data_out), 8'h0D);
    run_tx(0);
    check_basic("basic", 8'h0D);
    chk("basic done latency", done_cyc - start_cyc, 8);

    // Back-pressure on 0x22
    cap.delete(); hold22 = 0;
    start_pkt(2'd1, 6'd3, 1'b0);
    feed(0, 3, 0);
    run_tx(1);
    check_basic("backpressure", 8'h0D);
    chk("backpressure hold cycles", hold22, 4);

    // Rejected requests
    reject(2'd1, 6'd0, "len0");
    reject(2'd3, 6'd5, "dest3");

    // Maximum length with toggling source
    src_bytes.delete();
    for (int i = 0; i < 63; i++) src_bytes.push_back(8'($urandom));
    cap.delete();
    start_pkt(2'd2, 6'd63, 1'b0);
    feed(0, 62, 1);
    chk("max no header before last", int'(pkt_valid), 0);
    chk("max still loading", int'(src_ready), 1);
    feed(62, 1, 1);
    chk("max header", int'(data_out), 8'hFE);
    chk("max header valid", int'(pkt_valid), 1);
    run_tx(0);
    chk("max byte count", cap.size(), 65);
    if (cap.size() == 65) begin
      exp_par = 8'hFE;
      for (int i = 0; i < 63; i++) begin
        chk($sformatf("max byte%0d", i), int'(cap[i+1]), {1'b1, src_bytes[i]});
        exp_par ^= src_bytes[i];
      end
      chk("max parity", int'(cap[64]), {1'b0, exp_par});
    end

    // Reset mid-packet
    src_bytes = '{8'h11, 8'h22, 8'h33};
    start_pkt(2'd1, 6'd3, 1'b0);
    feed(0, 3, 0);
    tick();
    reset = 1'b1;
    tick();
    chk("midreset pkt_valid", int'(pkt_valid), 0);
    chk("midreset data_out", int'(data_out), 0);
    chk("midreset tx_active", int'(tx_active), 0);
    reset = 1'b0;
    tick();
    cap.delete();
    start_pkt(2'd1, 6'd3, 1'b0);
    feed(0, 3, 0);
    run_tx(0);
    check_basic("after reset", 8'h0D);

    // Parity corruption request
    cap.delete();
    start_pkt(2'd1, 6'd3, 1'b1);
    feed(0, 3, 0);
    run_tx(0);
    check_basic("corrupt", CorruptEn ? 8'h0C : 8'h0D);

    // Randomised packets
    for (int n = 0; n < 30; n++) begin
      logic [1:0] d;
      logic [5:0] l;
      d = 2'($urandom);
      l = ($urandom_range(3) == 0) ? 6'($urandom) : 6'($urandom_range(12));
      if (d == 2'd3 || l == 6'd0) begin
        reject(d, l, "random reject");
      end else begin
        src_bytes.delete();
        for (int i = 0; i < int'(l); i++) src_bytes.push_back(8'($urandom));
        start_pkt(d, l, 1'($urandom));
        feed(0, int'(l), 2);
        run_tx(2);
        if ($urandom_range(1) == 0) tick();
      end
    end

    repeat (2) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
